// File: rtl/btb_upd_sched.sv
// Branch target buffer update scheduler: queues resolved-branch updates, performs
// read-modify-write of the BTB entry, and sweeps the table to invalidate it on flush.
module btb_upd_sched #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int FIFO_D = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upd_valid_i,
  output logic                      upd_ready_o,
  input  logic [ADDR_W-1:0]         upd_pc_i,
  input  logic [ADDR_W-1:0]         upd_target_i,
  input  logic                      upd_taken_i,
  input  logic                      flush_req_i,
  output logic                      flush_busy_o,
  output logic                      flush_done_o,
  output logic                      rd_en_o,
  output logic [IDX_W-1:0]          rd_idx_o,
  input  logic                      rd_valid_i,
  input  logic [ADDR_W-IDX_W-3:0]   rd_tag_i,
  input  logic [1:0]                rd_ctr_i,
  output logic                      wr_en_o,
  output logic [IDX_W-1:0]          wr_idx_o,
  output logic                      wr_valid_o,
  output logic [ADDR_W-IDX_W-3:0]   wr_tag_o,
  output logic [ADDR_W-1:0]         wr_target_o,
  output logic [1:0]                wr_ctr_o
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, FLUSH} state_t;
  state_t state, state_n;

  logic [IDX_W-1:0]  q_idx   [FIFO_D];
  logic [TAG_W-1:0]  q_tag   [FIFO_D];
  logic [ADDR_W-1:0] q_tgt   [FIFO_D];
  logic              q_taken [FIFO_D];

  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] fl_idx;

  logic       push, pop, fifo_full, flush_enter, more, hit;
  logic [1:0] ctr_next;
  logic       pc_lo_unused;

  assign pc_lo_unused = ^upd_pc_i[1:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full   = (cnt == CNT_W'(FIFO_D));
  assign upd_ready_o = !fifo_full && (state != FLUSH);
  assign push        = upd_valid_i && upd_ready_o;
  // Occupancy after this cycle's pop and push, used to chain straight into the next read.
  assign more        = push || (cnt > CNT_W'(pop));
  assign flush_enter = (state_n == FLUSH) && (state != FLUSH);
  assign hit         = rd_valid_i && (rd_tag_i == q_tag[rp]);

  always_comb begin
    ctr_next = rd_ctr_i;
    if (q_taken[rp]) begin
      if (rd_ctr_i != 2'b11) ctr_next = rd_ctr_i + 2'd1;
    end else begin
      if (rd_ctr_i != 2'b00) ctr_next = rd_ctr_i - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wp]   <= upd_pc_i[IDX_W+1:2];
      q_tag[wp]   <= upd_pc_i[ADDR_W-1:IDX_W+2];
      q_tgt[wp]   <= upd_target_i;
      q_taken[wp] <= upd_taken_i;
    end
  end

  // Entering FLUSH discards the queue, including anything pushed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush_enter) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!push && pop) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                fl_idx <= '0;
    else if (flush_enter)   fl_idx <= '0;
    else if (state == FLUSH) fl_idx <= fl_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    rd_en_o      = 1'b0;
    rd_idx_o     = '0;
    wr_en_o      = 1'b0;
    wr_idx_o     = '0;
    wr_valid_o   = 1'b0;
    wr_tag_o     = '0;
    wr_target_o  = '0;
    wr_ctr_o     = '0;
    flush_busy_o = 1'b0;
    flush_done_o = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req_i)                 state_n = FLUSH;
        else if ((cnt != '0) || push)    state_n = RD;
      end
      RD: begin
        rd_en_o  = 1'b1;
        rd_idx_o = q_idx[rp];
        state_n  = flush_req_i ? FLUSH : WR;
      end
      WR: begin
        pop = 1'b1;
        if (hit || q_taken[rp]) begin
          wr_en_o     = 1'b1;
          wr_valid_o  = 1'b1;
          wr_idx_o    = q_idx[rp];
          wr_tag_o    = q_tag[rp];
          wr_target_o = q_tgt[rp];
          wr_ctr_o    = hit ? ctr_next : 2'b10;
        end
        if (flush_req_i) state_n = FLUSH;
        else if (more)   state_n = RD;
        else             state_n = IDLE;
      end
      FLUSH: begin
        flush_busy_o = 1'b1;
        wr_en_o      = 1'b1;
        wr_idx_o     = fl_idx;
        if (fl_idx == '1) begin
          flush_done_o = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/btb_upd_sched.md
BTB_UPD_SCHED -- requirements
Module: btb_upd_sched

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and target buses.
REQ-002 Parameter IDX_W, default 4, BTB index width; table has 2^IDX_W entries.
REQ-003 Parameter FIFO_D, default 2, update-queue depth.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 upd_valid_i  in  1  resolved-branch update request from execute.
REQ-007 upd_ready_o  out  1  update queue can accept this cycle.
REQ-008 upd_pc_i  in  ADDR_W  PC of the resolved branch.
REQ-009 upd_target_i  in  ADDR_W  resolved target.
REQ-010 upd_taken_i  in  1  branch resolved taken.
REQ-011 flush_req_i  in  1  request to invalidate the whole table (fence.i or context change).
REQ-012 flush_busy_o  out  1  flush sweep in progress.
REQ-013 flush_done_o  out  1  one-cycle pulse on the final flush write.
REQ-014 rd_en_o / rd_idx_o  out  1 / IDX_W  table read port; data returns the next cycle.
REQ-015 rd_valid_i / rd_tag_i / rd_ctr_i  in  1 / ADDR_W-IDX_W-2 / 2  read data: entry valid, tag, 2-bit counter.
REQ-016 wr_en_o / wr_idx_o  out  1 / IDX_W  table write strobe and index.
REQ-017 wr_valid_o / wr_tag_o / wr_target_o / wr_ctr_o  out  1 / ADDR_W-IDX_W-2 / ADDR_W / 2  write data.

Function
REQ-018 Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
REQ-019 Handshake: an update is pushed into the FIFO when upd_valid_i && upd_ready_o; upd_ready_o = !fifo_full && state!=FLUSH.
REQ-020 FSM states: IDLE, RD, WR, FLUSH.
REQ-021 IDLE: flush_req_i -> FLUSH; else FIFO non-empty -> RD; else stay.
REQ-022 RD: assert rd_en_o with rd_idx_o = head index; flush_req_i -> FLUSH with no write; else -> WR.
REQ-023 WR: rd_* data is valid; pop the FIFO head; on hit (rd_valid_i && rd_tag_i==head tag) wr_en_o=1, wr_valid_o=1, wr_target_o=head target, wr_ctr_o = saturating +1 if taken, else saturating -1.
REQ-024 WR miss: if taken, allocate wr_en_o=1, wr_valid_o=1, wr_ctr_o=2'b10; if not taken, wr_en_o=0.
REQ-025 WR exit: flush_req_i -> FLUSH; else FIFO non-empty after pop -> RD; else -> IDLE.
REQ-026 Counter saturates at 2'b11 and 2'b00; no wrap.
REQ-027 Latency: an update accepted at cycle T with an empty FIFO and the FSM in IDLE has rd_en_o at T+1 and its write (if any) at T+2; sustained throughput is one update per 2 cycles.
REQ-028 FLUSH entry: clear all FIFO contents (stale updates are discarded); the flush counter starts at 0.
REQ-029 FLUSH: each cycle wr_en_o=1, wr_valid_o=0, wr_idx_o=counter, wr_tag_o/wr_target_o/wr_ctr_o=0, then the counter increments; after index 2^IDX_W-1, flush_done_o=1 and the FSM goes to IDLE.
REQ-030 flush_busy_o=1 in every FLUSH cycle; flush_req_i during FLUSH is ignored.
REQ-031 wr_en_o and rd_en_o are never both asserted in the same cycle.
REQ-032 FIFO full with upd_valid_i high: upd_ready_o=0 and the request is not pushed; a simultaneous pop does not free a slot until the next cycle.

Reset
REQ-033 While rst is high, and after it deasserts: state=IDLE, FIFO empty, flush counter=0, all outputs 0 except upd_ready_o=1.
REQ-034 Reset asserted mid-RD/WR/FLUSH aborts the operation immediately with no further write.

Verification
REQ-035 Miss + taken: pc=0x0000_1008, tgt=0x2000, rd_valid_i=0 -> at T+2 wr_idx_o=2, wr_tag_o=0x40, wr_ctr_o=2'b10, wr_valid_o=1.
REQ-036 Hit + not-taken, rd_ctr_i=2'b00 -> wr_ctr_o=2'b00; hit + taken, rd_ctr_i=2'b11 -> wr_ctr_o=2'b11.
REQ-037 Three back-to-back updates with FIFO_D=2 -> upd_ready_o falls after 2 accepts; writes at T+2, T+4, T+6.
REQ-038 flush_req_i during RD with 2 queued -> no update write; 16 invalid writes (idx 0..15); flush_done_o on the 16th; FIFO empty afterwards.
REQ-039 rst pulse mid-FLUSH at idx 7 -> wr_en_o=0 immediately; IDLE after release; next update follows REQ-027 timing.
